counter_prog: RTL and testbench
===============================

# counter_prog

Programmable counter: up/down counting to a runtime limit, with wrap, saturate or one-shot terminal behaviour, a clock-enable prescaler, start/stop control and synchronous load/clear. Widens the team's free-running overflow counter to configurable width and terminal value. Serves as the common timer/event-count primitive for peripheral and test-harness blocks.

## Interface
- COUNT_W, 16: counter width, ≥2.
- PRE_W, 8: prescaler width, ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear, highest priority.
- load  in  1  synchronous load of load_val.
- load_val  in  COUNT_W  load value.
- start  in  1  pulse: IDLE/DONE -> RUN.
- stop  in  1  pulse: RUN -> IDLE.
- dir  in  1  0 = up, 1 = down; sampled on every step.
- mode  in  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = reserved (behaves as wrap).
- limit  in  COUNT_W  terminal value for up-counting and reload value for down-counting.
- presc  in  PRE_W  one step every presc+1 cycles.
- count  out  COUNT_W  current value.
- tc  out  1  one-cycle terminal-event pulse.
- at_term  out  1  level: count equals the terminal for the current dir.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

## Operation
- States: IDLE, RUN, DONE. Reset and clr both enter IDLE.
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE. One-shot terminal event -> DONE.
  - DONE: start -> RUN, with count unchanged; reload with load first.
- Priority per cycle: clr > load > stop > start > step.
  - load does not change state. It suppresses the step in that cycle and resets the prescaler phase.
  - stop and start together in RUN: stop wins.
- Step: occurs only in RUN, on a prescaler tick.
- Terminal condition:
  - Up: count >= limit. An out-of-range loaded value is therefore terminal on its first step.
  - Down: count == 0.
- Non-terminal step: count ± 1, modulo 2^COUNT_W.
- Terminal step, all modes: tc = 1 for one cycle. Action by mode:
  - Wrap: up -> 0; down -> limit.
  - Saturate: count holds. tc pulses on every terminal step, so it recurs at the prescaled rate.
  - One-shot: count holds, state -> DONE.
- limit = 0, up: every step is terminal (count stays 0 in wrap).
- at_term is combinational from count, limit and dir: up -> (count == limit); down -> (count == 0).
- mode, dir, limit and presc may change at any time; new values take effect on the next step or tick.

## Timing
- Reset values: count = 0, tc = 0, busy = 0, done = 0, state IDLE, prescaler = 0. at_term follows its equation.
- count, tc, busy and done are registered. tc rises in the same cycle count shows the post-terminal value.
- Prescaler:
  - Zeroed on reset, clr, load and on the start transition.
  - In RUN, ticks when it equals presc, then returns to 0.
  - Holds outside RUN.
- First step: presc+1 cycles after the edge that sampled start. presc = 0 gives one step per cycle from the next edge.
- busy rises the cycle after start is sampled and falls the cycle after stop is sampled or the one-shot terminal is reached.
- done rises together with the one-shot tc.
- clr during RUN or DONE: the next cycle shows count = 0, IDLE, tc = 0.
- rst_n assertion mid-count clears immediately (asynchronous). Deassertion is synchronised outside this block.

## Structure
- Shared package counter_pkg:
  - mode encoding: MODE_WRAP = 0, MODE_SAT = 1, MODE_ONESHOT = 2.
  - state enum: ST_IDLE, ST_RUN, ST_DONE.
- Sub-module counter_prescaler (PRE_W): inputs run, restart, presc; output tick.
- Top level holds the FSM, the count register and the terminal logic.

## Test plan
- COUNT_W = 4, limit = 5, up, wrap, presc = 0, start -> count 1,2,3,4,5,0,1… on consecutive cycles; tc high only in the cycle count = 0; busy = 1 throughout.
- Down, wrap, limit = 3, load 2, start -> 1,0,3,2…; tc high with count = 3.
- Up, one-shot, limit = 4, presc = 2 -> a step every 3 cycles; count stops at 4, done = 1, busy = 0, tc one cycle only. A second start gives tc one step later, count still 4.
- Saturate, up, limit = 15 (COUNT_W = 4), from 13 -> 14,15,15,15; tc pulses on each step at 15; at_term = 1.
- Mid-run clr together with load and start -> next cycle count = 0, IDLE, busy = 0. Then load_val = 9 with limit = 5, up, wrap, start -> first step gives count 0 with tc.
- rst_n low mid-count, asynchronous to clk -> count = 0 and busy = 0 before the next edge; start stop together in RUN -> IDLE.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared mode encodings and FSM state type for counter_prog
package counter_pkg;
  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: clock-enable divider, one tick every presc+1 running cycles
module counter_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic [PRE_W-1:0] presc,
  output logic             tick
);
  logic [PRE_W-1:0] cnt_q, cnt_d;
  assign tick = run && cnt_q == presc;
  // restart zeroes the phase; the phase freezes while not running
  always_comb cnt_d = restart ? '0 : !run ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  // phase register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/counter_prog.sv
// counter_prog: programmable up/down counter with wrap/saturate/one-shot terminal behaviour
module counter_prog
  import counter_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int PRE_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] limit,
  input  logic [PRE_W-1:0]   presc,
  output logic [COUNT_W-1:0] count,
  output logic               tc,
  output logic               at_term,
  output logic               busy,
  output logic               done
);
  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               tc_q, tc_d;
  logic               running, tick, go, step, term, hold;
  assign running = state_q == ST_RUN;
  assign go      = start && !running && !clr && !load;
  assign step    = running && tick && !clr && !load && !stop;
  assign term    = dir ? count_q == '0 : count_q >= limit;
  assign hold    = mode == MODE_SAT || mode == MODE_ONESHOT;
  counter_prescaler #(.PRE_W(PRE_W)) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (running),
    .restart (clr || load || go),
    .presc   (presc),
    .tick    (tick)
  );
  // next count, terminal pulse and state under clr > load > stop > start > step
  always_comb begin
    count_d = clr ? '0 : load ? load_val : !step ? count_q :
              !term ? (dir ? count_q - 1'b1 : count_q + 1'b1) :
              hold ? count_q : dir ? limit : '0;
    tc_d    = step && term;
    state_d = clr ? ST_IDLE : load ? state_q : (stop && running) ? ST_IDLE :
              go ? ST_RUN : (tc_d && mode == MODE_ONESHOT) ? ST_DONE : state_q;
  end
  // state, count and pulse registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  assign count   = count_q;
  assign tc      = tc_q;
  assign busy    = state_q == ST_RUN;
  assign done    = state_q == ST_DONE;
  assign at_term = dir ? count_q == '0 : count_q == limit;
endmodule

// File: tb/tb_counter_prog.sv
// tb_counter_prog: scoreboard bench for counter_prog with directed vectors
module tb_counter_prog;
  typedef struct {
    int          t;
    string       nm;
    logic [7:0]  v;
  } exp_t;
  logic       clk = 0, rst_n = 0, clr = 0, load = 0, start = 0, stop = 0, dir = 0;
  logic [3:0] load_val = 0, limit = 5, presc = 0, count;
  logic [1:0] mode = 0;
  logic       tc, at_term, busy, done;
  int         cyc = 0, errors = 0, checks = 0;
  exp_t       q[$];
  exp_t       me;
  counter_prog #(.COUNT_W(4), .PRE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .dir(dir), .mode(mode), .limit(limit),
    .presc(presc), .count(count), .tc(tc), .at_term(at_term), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b at_term=%b, expected count=%0d tc=%b busy=%b done=%b at_term=%b",
               nm, got[7:4], got[3], got[2], got[1], got[0], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask
  // monitor: compare each expectation in the cycle it is due
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].t <= cyc) begin
      me = q.pop_front();
      if (me.t < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d not compared, now cycle %0d", me.nm, me.t, cyc);
      end else
        check(me.nm, {count, tc, busy, done, at_term}, me.v);
    end
  end
  task automatic cy(input string nm, input logic [3:0] c, input logic t, b, d, a);
    q.push_back('{cyc + 1, nm, {c, t, b, d, a}});
    @(negedge clk);
    #1;
    start = 0;
    stop  = 0;
    clr   = 0;
    load  = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    #1;
    cy("reset", 0, 0, 0, 0, 0);
    rst_n = 1;
    // up, wrap, limit 5, one step per cycle
    start = 1;
    cy("up_start", 0, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) cy("up_step", 4'(k), 0, 1, 0, 0);
    cy("up_at5", 5, 0, 1, 0, 1);
    cy("up_wrap", 0, 1, 1, 0, 0);
    cy("up_after", 1, 0, 1, 0, 0);
    stop = 1;
    cy("up_stop", 1, 0, 0, 0, 0);
    // down, wrap, limit 3, from 2
    dir = 1; limit = 3; load = 1; load_val = 2;
    cy("dn_load", 2, 0, 0, 0, 0);
    start = 1;
    cy("dn_start", 2, 0, 1, 0, 0);
    cy("dn_1", 1, 0, 1, 0, 0);
    cy("dn_0", 0, 0, 1, 0, 1);
    cy("dn_wrap", 3, 1, 1, 0, 0);
    cy("dn_2", 2, 0, 1, 0, 0);
    stop = 1;
    cy("dn_stop", 2, 0, 0, 0, 0);
    // up, one-shot, limit 4, presc 2
    dir = 0; mode = 2; limit = 4; presc = 2; load = 1; load_val = 0;
    cy("os_load", 0, 0, 0, 0, 0);
    start = 1;
    cy("os_start", 0, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cy("os_hold", 4'(k - 1), 0, 1, 0, 0);
      cy("os_hold", 4'(k - 1), 0, 1, 0, 0);
      cy("os_step", 4'(k), 0, 1, 0, 1'(k == 4));
    end
    cy("os_hold4", 4, 0, 1, 0, 1);
    cy("os_hold4", 4, 0, 1, 0, 1);
    cy("os_tc", 4, 1, 0, 1, 1);
    cy("os_done", 4, 0, 0, 1, 1);
    start = 1;
    cy("os_restart", 4, 0, 1, 0, 1);
    cy("os_re_hold", 4, 0, 1, 0, 1);
    cy("os_re_hold", 4, 0, 1, 0, 1);
    cy("os_re_tc", 4, 1, 0, 1, 1);
    cy("os_re_done", 4, 0, 0, 1, 1);
    // saturate, up, limit 15, from 13
    mode = 1; limit = 15; presc = 0; load = 1; load_val = 13;
    cy("sat_load", 13, 0, 0, 1, 0);
    start = 1;
    cy("sat_start", 13, 0, 1, 0, 0);
    cy("sat_14", 14, 0, 1, 0, 0);
    cy("sat_15", 15, 0, 1, 0, 1);
    cy("sat_tc1", 15, 1, 1, 0, 1);
    cy("sat_tc2", 15, 1, 1, 0, 1);
    // clr beats load and start mid-run
    clr = 1; load = 1; load_val = 7; start = 1;
    cy("clr_all", 0, 0, 0, 0, 0);
    // out-of-range load is terminal on the first step
    mode = 0; limit = 5; load = 1; load_val = 9;
    cy("oor_load", 9, 0, 0, 0, 0);
    start = 1;
    cy("oor_start", 9, 0, 1, 0, 0);
    cy("oor_wrap", 0, 1, 1, 0, 0);
    cy("oor_1", 1, 0, 1, 0, 0);
    // start and stop together in RUN: stop wins
    start = 1; stop = 1;
    cy("ss_stop", 1, 0, 0, 0, 0);
    start = 1;
    cy("ss_start", 1, 0, 1, 0, 0);
    cy("ss_2", 2, 0, 1, 0, 0);
    cy("ss_3", 3, 0, 1, 0, 0);
    // asynchronous reset between edges
    #2 rst_n = 0;
    #1 check("async_rst", {count, tc, busy, done, at_term}, 8'b0000_0000);
    @(negedge clk);
    #1;
    cy("rst_hold", 0, 0, 0, 0, 0);
    rst_n = 1;
    cy("post_rst", 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
